// File: rtl/mm_sram_ctrl_if.sv
// Request/response bundle between the mm pipeline stage and its data-memory controller.
// The mm stage is the master; the SRAM controller is the slave.
interface mm_sram_ctrl_if;
   logic        mem_access_read;
   logic        mem_access_write;
   logic [2:0]  mem_access_size;
   logic [31:0] mem_access_addr;
   logic [31:0] mem_access_data_out;
   logic [31:0] mem_access_data_in;
   logic        stall_o;
   logic        align_err_o;

   modport master (
      output mem_access_read, mem_access_write, mem_access_size, mem_access_addr,
             mem_access_data_out,
      input  mem_access_data_in, stall_o, align_err_o
   );

   modport slave (
      input  mem_access_read, mem_access_write, mem_access_size, mem_access_addr,
             mem_access_data_out,
      output mem_access_data_in, stall_o, align_err_o
   );
endinterface

// File: rtl/mm_sram_ctrl.sv
// Multi-cycle controller for an asynchronous 32-bit SRAM behind the mm stage.
// It stalls the pipeline for WAIT_CYCLES+1 cycles per access and returns the raw read word.
module mm_sram_ctrl #(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned SRAM_AW     = 20
) (
   input  logic               clk,
   input  logic               rst_n,
   mm_sram_ctrl_if.slave      mm,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [31:0]        sram_data_o,
   output logic               sram_data_oe,
   input  logic [31:0]        sram_data_i,
   output logic               sram_ce_n,
   output logic               sram_oe_n,
   output logic               sram_we_n,
   output logic [3:0]         sram_be_n
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StAccess = 2'd1;
   localparam logic [1:0] StDone   = 2'd2;

   localparam logic [2:0] SzByte  = 3'd0;
   localparam logic [2:0] SzHalf  = 3'd1;
   localparam logic [2:0] SzWord  = 3'd2;
   localparam logic [2:0] SzLeft  = 3'd3;
   localparam logic [2:0] SzRight = 3'd4;

   localparam logic [3:0] CntInit = 4'(WAIT_CYCLES - 1);

   logic [1:0]         state_q;
   logic [3:0]         cnt_q;
   logic               write_q;
   logic [SRAM_AW-1:0] addr_q;
   logic [31:0]        data_q;
   logic [3:0]         be_q;
   logic [31:0]        rdata_q;

   logic       req;
   logic       align_err;
   logic       start;
   logic [1:0] a;
   logic [3:0] be_req;
   logic       unused_addr;

   assign req         = mm.mem_access_read | mm.mem_access_write;
   assign a           = mm.mem_access_addr[1:0];
   assign unused_addr = ^mm.mem_access_addr[31:SRAM_AW+2];

   always_comb begin
      align_err = 1'b0;
      if (req) begin
         if (mm.mem_access_size == SzHalf) align_err = a[0];
         if (mm.mem_access_size == SzWord) align_err = (a != 2'd0);
      end
   end

   assign start = req & ~align_err;

   // Unmapped size codes enable no lanes, so a stray write cannot corrupt memory.
   always_comb begin
      case (mm.mem_access_size)
         SzByte:  be_req = 4'b0001 << a;
         SzHalf:  be_req = a[1] ? 4'b1100 : 4'b0011;
         SzWord:  be_req = 4'b1111;
         SzLeft:  be_req = 4'b1111 >> (2'd3 - a);
         SzRight: be_req = 4'b1111 << a;
         default: be_req = 4'b0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         write_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= 32'd0;
         be_q    <= 4'd0;
         rdata_q <= 32'd0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start) begin
                  state_q <= StAccess;
                  cnt_q   <= CntInit;
                  write_q <= mm.mem_access_write;
                  addr_q  <= mm.mem_access_addr[SRAM_AW+1:2];
                  data_q  <= mm.mem_access_data_out;
                  be_q    <= be_req;
               end
            end
            StAccess: begin
               if (cnt_q == 4'd0) begin
                  state_q <= StDone;
                  if (!write_q) rdata_q <= sram_data_i;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   // Write address/data stay driven through DONE to meet SRAM hold time after WE_n rises.
   always_comb begin
      sram_ce_n    = 1'b1;
      sram_oe_n    = 1'b1;
      sram_we_n    = 1'b1;
      sram_be_n    = 4'hF;
      sram_data_oe = 1'b0;
      case (state_q)
         StAccess: begin
            sram_ce_n = 1'b0;
            if (write_q) begin
               sram_we_n    = 1'b0;
               sram_data_oe = 1'b1;
               sram_be_n    = ~be_q;
            end else begin
               sram_oe_n = 1'b0;
               sram_be_n = 4'h0;
            end
         end
         StDone:  sram_data_oe = write_q;
         default: ;
      endcase
   end

   assign sram_addr             = addr_q;
   assign sram_data_o           = data_q;
   assign mm.mem_access_data_in = rdata_q;
   assign mm.align_err_o        = align_err;
   assign mm.stall_o            = ((state_q == StIdle) & start) | (state_q == StAccess);

endmodule
